// File: rtl/mem_ctrl_ws.sv
// mem_ctrl_ws: word RAM with configurable wait states, Busy/Done handshake and illegal-request Error.
// Optional MEMCTRL_PARITY_EN adds a stored even-parity bit per word, checked on reads.
`default_nettype none

module mem_ctrl_ws #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int DEPTH       = 512,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              Read,
  input  logic              Write,
  input  logic [ADDR_W-1:0] Address_Signal,
  input  logic [DATA_W-1:0] Data_Signal,
  output logic [DATA_W-1:0] BusMuxIn,
  output logic              Busy,
  output logic              Done,
  output logic              Error
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_XFER = 2'd2;

  localparam logic [3:0]      WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

`ifdef MEMCTRL_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  logic [1:0]        state;
  logic [3:0]        wait_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              op_write;
  logic [MEM_W-1:0]  mem [DEPTH];
  logic [MEM_W-1:0]  rd_word;
  logic [MEM_W-1:0]  wr_word;
  logic              addr_bad;
  logic              parity_bad;

  assign addr_bad = ({1'b0, Address_Signal} >= DEPTH_LIM);
  assign rd_word  = mem[addr_q];

`ifdef MEMCTRL_PARITY_EN
  assign wr_word    = {^data_q, data_q};
  assign parity_bad = ^rd_word;
`else
  assign wr_word    = data_q;
  assign parity_bad = 1'b0;
`endif

  // Array has no reset; the write is gated by state, so an async clr aborts it.
  always_ff @(posedge clk) begin
    if (state == ST_XFER && op_write) begin
      mem[addr_q] <= wr_word;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
      addr_q   <= '0;
      data_q   <= '0;
      op_write <= 1'b0;
      BusMuxIn <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Error    <= 1'b0;
    end else begin
      Done  <= 1'b0;
      Error <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Read && Write) begin
            Error <= 1'b1;
          end else if (Read || Write) begin
            if (addr_bad) begin
              Error <= 1'b1;
            end else begin
              addr_q   <= Address_Signal;
              data_q   <= Data_Signal;
              op_write <= Write;
              Busy     <= 1'b1;
              if (WAIT_STATES > 0) begin
                state    <= ST_WAIT;
                wait_cnt <= WAIT_INIT;
              end else begin
                state <= ST_XFER;
              end
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state <= ST_XFER;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_XFER: begin
          Busy  <= 1'b0;
          Done  <= 1'b1;
          state <= ST_IDLE;
          if (!op_write) begin
            BusMuxIn <= rd_word[DATA_W-1:0];
            Error    <= parity_bad;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
